// File: rtl/vsi_rx_pkg.sv
// vsi_rx_pkg
// Shared types and constants for the receive-side message buffer.
//   bank_state_t : lifecycle of one ping-pong bank (FREE / FILL / READY)
//   wr_state_t   : receiver write-handshake states (W_IDLE / W_ACK / W_WAIT)
//   msg_desc_t   : per-bank descriptor presented to the host (flag, len, line)
//   CNT_MAX      : saturation value of the error counters
//   sat_inc      : saturating increment used by those counters
package vsi_rx_pkg;

  typedef logic [1:0] bank_state_t;
  localparam bank_state_t FREE  = 2'd0;
  localparam bank_state_t FILL  = 2'd1;
  localparam bank_state_t READY = 2'd2;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t W_IDLE = 2'd0;
  localparam wr_state_t W_ACK  = 2'd1;
  localparam wr_state_t W_WAIT = 2'd2;

  typedef struct packed {
    logic [7:0]  flag;
    logic [15:0] len;
    logic        line;
  } msg_desc_t;

  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// rx_buf_ram
// Simple dual-port byte RAM holding both ping-pong banks; the bank select
// is the MSB of each address.
//   clk, rst_h        : clock and async active-high reset (read register only)
//   wr_en/addr/data   : synchronous write port
//   rd_en/addr        : read port request
//   rd_data           : registered read data, updated only when rd_en is high
module rx_buf_ram
  import vsi_rx_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_h,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**(ADDR_W+1)];

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between host reads.
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_msg_buffer.sv
// rx_msg_buffer
// Buffers messages from the vsi protocol receiver into two ping-pong banks.
// Only messages the receiver marks correct are committed and offered to the
// host; bad/overflowing messages and messages with no free bank are counted.
//   clk, rst_h                 : clock, async active-high reset
//   wr_req/wr_rdy/wr_addr/wr_data : receiver RAM-write handshake
//   hdr_valid/hdr_flag/hdr_len : message start with its descriptor
//   msg_end/msg_ok/msg_line    : message end with status and receive line
//   msg_avail, msg_*_o         : readable message and its descriptor
//   msg_ack                    : host releases the readable message
//   rd_en/rd_addr/rd_data      : host byte read of the readable bank
//   bad_cnt/drop_cnt           : saturating discard counters
module rx_msg_buffer
  import vsi_rx_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_h,
  input  logic              wr_req,
  output logic              wr_rdy,
  input  logic [15:0]       wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              hdr_valid,
  input  logic [7:0]        hdr_flag,
  input  logic [15:0]       hdr_len,
  input  logic              msg_end,
  input  logic              msg_ok,
  input  logic              msg_line,
  output logic              msg_avail,
  output logic [7:0]        msg_flag_o,
  output logic [15:0]       msg_len_o,
  output logic              msg_line_o,
  input  logic              msg_ack,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        bad_cnt,
  output logic [7:0]        drop_cnt
);

  localparam logic [16:0] BANK_BYTES = 17'(1) << ADDR_W;

  bank_state_t bank_st [2];
  msg_desc_t   desc    [2];
  wr_state_t   wr_st;
  logic        fill_ptr;
  logic        rd_ptr;
  logic        discard;
  logic        overflow;

  logic        fill_open;
  logic        addr_in_bank;
  logic        hdr_too_long;
  logic        ram_we;

  assign fill_open    = (bank_st[fill_ptr] == FILL);
  assign addr_in_bank = ({1'b0, wr_addr} < BANK_BYTES);
  assign hdr_too_long = ({1'b0, hdr_len} > BANK_BYTES);

  // The byte is committed on the edge that ends the W_ACK cycle, and only
  // into an open, non-discarded message at an in-range address.
  assign ram_we = (wr_st == W_ACK) && fill_open && !discard && addr_in_bank;

  assign wr_rdy     = (wr_st == W_ACK);
  assign msg_avail  = (bank_st[rd_ptr] == READY);
  assign msg_flag_o = desc[rd_ptr].flag;
  assign msg_len_o  = desc[rd_ptr].len;
  assign msg_line_o = desc[rd_ptr].line;

  // Write handshake: one wr_rdy pulse per request, then wait for the
  // receiver to drop wr_req before another request can be accepted.
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      wr_st <= W_IDLE;
    end else begin
      case (wr_st)
        W_IDLE:  if (wr_req) wr_st <= W_ACK;
        W_ACK:   wr_st <= W_WAIT;
        W_WAIT:  if (!wr_req) wr_st <= W_IDLE;
        default: wr_st <= W_IDLE;
      endcase
    end
  end

  // Bank bookkeeping. The fill side only ever touches bank[fill_ptr] while
  // it is FREE/FILL and the host side only touches bank[rd_ptr] while it is
  // READY, so a same-edge msg_end and msg_ack never collide.
  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      desc[0]    <= '0;
      desc[1]    <= '0;
      fill_ptr   <= 1'b0;
      rd_ptr     <= 1'b0;
      discard    <= 1'b0;
      overflow   <= 1'b0;
      bad_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if ((wr_st == W_ACK) && fill_open && !discard && !addr_in_bank)
        overflow <= 1'b1;

      if (hdr_valid) begin
        // A header on a still-open message abandons it; the same bank is
        // then immediately reopened for the new message.
        if (bank_st[fill_ptr] != READY) begin
          if (fill_open) bad_cnt <= sat_inc(bad_cnt);
          bank_st[fill_ptr]   <= FILL;
          desc[fill_ptr].flag <= hdr_flag;
          desc[fill_ptr].len  <= hdr_len;
          overflow            <= hdr_too_long;
          discard             <= 1'b0;
        end else begin
          discard <= 1'b1;
        end
      end else if (msg_end) begin
        if (fill_open) begin
          if (msg_ok && !overflow) begin
            bank_st[fill_ptr]   <= READY;
            desc[fill_ptr].line <= msg_line;
            fill_ptr            <= ~fill_ptr;
          end else begin
            bank_st[fill_ptr] <= FREE;
            bad_cnt           <= sat_inc(bad_cnt);
          end
        end else if (discard) begin
          drop_cnt <= sat_inc(drop_cnt);
          discard  <= 1'b0;
        end
      end

      if (msg_ack && msg_avail) begin
        bank_st[rd_ptr] <= FREE;
        rd_ptr          <= ~rd_ptr;
      end
    end
  end

  rx_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst_h   (rst_h),
    .wr_en   (ram_we),
    .wr_addr ({fill_ptr, wr_addr[ADDR_W-1:0]}),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_ptr, rd_addr}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_rx_msg_buffer.sv
// tb_rx_msg_buffer
// Directed scenarios plus randomized traffic for rx_msg_buffer, checked every
// cycle against a message-level model: a queue of committed messages (at most
// two fit), the currently open message, and byte contents keyed by message id.
module tb_rx_msg_buffer;

  localparam int ADDR_W = 10;
  localparam int BANK   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_h = 1'b1;
  logic              wr_req = 1'b0;
  logic              wr_rdy;
  logic [15:0]       wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              hdr_valid = 1'b0;
  logic [7:0]        hdr_flag = '0;
  logic [15:0]       hdr_len = '0;
  logic              msg_end = 1'b0;
  logic              msg_ok = 1'b0;
  logic              msg_line = 1'b0;
  logic              msg_avail;
  logic [7:0]        msg_flag_o;
  logic [15:0]       msg_len_o;
  logic              msg_line_o;
  logic              msg_ack = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic [7:0]        bad_cnt;
  logic [7:0]        drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rx_msg_buffer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_h      (rst_h),
    .wr_req     (wr_req),
    .wr_rdy     (wr_rdy),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .hdr_valid  (hdr_valid),
    .hdr_flag   (hdr_flag),
    .hdr_len    (hdr_len),
    .msg_end    (msg_end),
    .msg_ok     (msg_ok),
    .msg_line   (msg_line),
    .msg_avail  (msg_avail),
    .msg_flag_o (msg_flag_o),
    .msg_len_o  (msg_len_o),
    .msg_line_o (msg_line_o),
    .msg_ack    (msg_ack),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .bad_cnt    (bad_cnt),
    .drop_cnt   (drop_cnt)
  );

  // Message-level reference model
  typedef struct packed {
    logic [31:0] id;
    logic [7:0]  flag;
    logic [15:0] len;
    logic        line;
  } msg_t;

  msg_t        ready_q[$];
  msg_t        cur;
  int          open_mode;     // 0 = none, 1 = filling, 2 = discarding
  bit          cur_ovf;
  int          next_id;
  logic [7:0]  mem_m [int];
  int          m_bad, m_drop;
  bit          m_rdy, m_busy;
  logic [7:0]  m_rd;
  bit          m_rd_valid;
  bit          m_avail_pre, m_room, m_commit;

  function automatic int mkey(input logic [31:0] id, input int addr);
    return int'(id) * 2048 + addr;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    next_id = 0;
    forever begin
      @(posedge clk or posedge rst_h);
      if (rst_h) begin
        ready_q.delete();
        open_mode  = 0;
        cur_ovf    = 0;
        m_bad      = 0;
        m_drop     = 0;
        m_rdy      = 0;
        m_busy     = 0;
        m_rd       = '0;
        m_rd_valid = 1;
      end else begin
        m_avail_pre = (ready_q.size() > 0);
        m_room      = (ready_q.size() < 2);
        m_commit    = 0;
        if (rd_en) begin
          if (m_avail_pre && mem_m.exists(mkey(ready_q[0].id, int'(rd_addr)))) begin
            m_rd       = mem_m[mkey(ready_q[0].id, int'(rd_addr))];
            m_rd_valid = 1;
          end else begin
            m_rd_valid = 0;
          end
        end
        if (m_rdy) begin
          if (open_mode == 1) begin
            if (int'(wr_addr) < BANK) mem_m[mkey(cur.id, int'(wr_addr))] = wr_data;
            else cur_ovf = 1;
          end
          m_rdy  = 0;
          m_busy = 1;
        end else if (m_busy) begin
          if (!wr_req) m_busy = 0;
        end else begin
          m_rdy = wr_req;
        end
        if (hdr_valid) begin
          if (open_mode == 1) m_bad = sat(m_bad + 1);
          if (m_room) begin
            open_mode = 1;
            cur.id    = 32'(next_id);
            next_id++;
            cur.flag  = hdr_flag;
            cur.len   = hdr_len;
            cur.line  = 1'b0;
            cur_ovf   = (int'(hdr_len) > BANK);
          end else begin
            open_mode = 2;
          end
        end else if (msg_end) begin
          if (open_mode == 1) begin
            if (msg_ok && !cur_ovf) begin
              cur.line = msg_line;
              m_commit = 1;
            end else begin
              m_bad = sat(m_bad + 1);
            end
          end else if (open_mode == 2) begin
            m_drop = sat(m_drop + 1);
          end
          open_mode = 0;
        end
        if (msg_ack && m_avail_pre) void'(ready_q.pop_front());
        if (m_commit) ready_q.push_back(cur);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("cyc_avail", 32'(msg_avail), 32'(ready_q.size() > 0));
    if (ready_q.size() > 0) begin
      checkOutput("cyc_flag", 32'(msg_flag_o), 32'(ready_q[0].flag));
      checkOutput("cyc_len",  32'(msg_len_o),  32'(ready_q[0].len));
      checkOutput("cyc_line", 32'(msg_line_o), 32'(ready_q[0].line));
    end
    checkOutput("cyc_bad",    32'(bad_cnt),  32'(m_bad));
    checkOutput("cyc_drop",   32'(drop_cnt), 32'(m_drop));
    checkOutput("cyc_wr_rdy", 32'(wr_rdy),   32'(m_rdy));
    if (m_rd_valid) checkOutput("cyc_rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  // Every-cycle comparison, one time step after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_h) compareModel();
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus helpers; each starts and ends on a falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_h = 1'b1;
    tick();
    rst_h = 1'b0;
  endtask

  task automatic do_hdr(input logic [7:0] f, input logic [15:0] l);
    hdr_valid = 1'b1;
    hdr_flag  = f;
    hdr_len   = l;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic do_end(input bit ok, input bit line, input bit ack);
    msg_end  = 1'b1;
    msg_ok   = ok;
    msg_line = line;
    msg_ack  = ack;
    tick();
    msg_end = 1'b0;
    msg_ack = 1'b0;
  endtask

  task automatic do_ack();
    msg_ack = 1'b1;
    tick();
    msg_ack = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    rd_addr = a;
    rd_en   = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wait_rdy();
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      seen = wr_rdy;
    end
    checkOutput("wr_rdy_seen", 32'(seen), 1);
    wr_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    wait_rdy();
  endtask

  task automatic applyStimulus(input int n);
    for (int it = 0; it < n; it++) begin
      int r = $urandom_range(0, 99);
      if (r < 6) begin
        do_write(16'($urandom_range(0, 15)), 8'($urandom));
      end else if (r < 10) begin
        do_end(1'($urandom), 1'($urandom), 1'b0);
      end else if (r < 18) begin
        do_ack();
      end else if (r < 32) begin
        do_read(ADDR_W'($urandom_range(0, 9)));
      end else begin
        int nw = $urandom_range(0, 4);
        logic [15:0] len;
        len = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1025, 1100))
                                          : 16'($urandom_range(1, 16));
        do_hdr(8'($urandom), len);
        for (int k = 0; k < nw; k++) begin
          logic [15:0] a;
          a = ($urandom_range(0, 11) == 0) ? 16'($urandom_range(1024, 1030))
                                           : 16'($urandom_range(0, 9));
          do_write(a, 8'($urandom));
        end
        if ($urandom_range(0, 9) != 0)
          do_end($urandom_range(0, 6) != 0, 1'($urandom), $urandom_range(0, 4) == 0);
      end
    end
  endtask

  initial begin
    int pulses;
    bool_dummy: begin end
    repeat (2) tick();
    rst_h = 1'b0;

    // Reset values
    checkOutput("rst_avail",  32'(msg_avail),  0);
    checkOutput("rst_flag",   32'(msg_flag_o), 0);
    checkOutput("rst_len",    32'(msg_len_o),  0);
    checkOutput("rst_line",   32'(msg_line_o), 0);
    checkOutput("rst_rd",     32'(rd_data),    0);
    checkOutput("rst_bad",    32'(bad_cnt),    0);
    checkOutput("rst_drop",   32'(drop_cnt),   0);
    checkOutput("rst_wr_rdy", 32'(wr_rdy),     0);

    // Basic good message
    do_hdr(8'h11, 16'd4);
    for (int i = 0; i < 4; i++) do_write(16'(i), 8'(8'hA0 + i));
    do_end(1'b1, 1'b1, 1'b0);
    checkOutput("t1_avail", 32'(msg_avail),  1);
    checkOutput("t1_flag",  32'(msg_flag_o), 'h11);
    checkOutput("t1_len",   32'(msg_len_o),  4);
    checkOutput("t1_line",  32'(msg_line_o), 1);
    checkOutput("t1_model_q", 32'(ready_q.size()), 1);
    for (int i = 0; i < 4; i++) begin
      do_read(ADDR_W'(i));
      checkOutput("t1_rd", 32'(rd_data), 32'('hA0 + i));
    end

    // Bad message, then the bank is reused
    do_reset();
    do_hdr(8'h11, 16'd4);
    for (int i = 0; i < 4; i++) do_write(16'(i), 8'(8'hA0 + i));
    do_end(1'b0, 1'b1, 1'b0);
    checkOutput("t2_avail", 32'(msg_avail), 0);
    checkOutput("t2_bad",   32'(bad_cnt),   1);
    do_hdr(8'h33, 16'd1);
    do_write(16'd0, 8'h77);
    do_end(1'b1, 1'b0, 1'b0);
    checkOutput("t2_avail2", 32'(msg_avail),  1);
    checkOutput("t2_flag2",  32'(msg_flag_o), 'h33);
    do_read('0);
    checkOutput("t2_rd", 32'(rd_data), 'h77);

    // Three good messages without ack: third dropped, order preserved
    do_reset();
    for (int m = 0; m < 3; m++) begin
      do_hdr(8'(8'h21 + m), 16'd1);
      do_write(16'd0, 8'(8'h21 + m));
      do_end(1'b1, 1'b0, 1'b0);
    end
    checkOutput("t3_drop",  32'(drop_cnt),   1);
    checkOutput("t3_model_drop", 32'(m_drop), 1);
    checkOutput("t3_flag1", 32'(msg_flag_o), 'h21);
    do_ack();
    checkOutput("t3_avail2", 32'(msg_avail),  1);
    checkOutput("t3_flag2",  32'(msg_flag_o), 'h22);
    do_read('0);
    checkOutput("t3_rd2", 32'(rd_data), 'h22);
    do_ack();
    checkOutput("t3_avail_none", 32'(msg_avail), 0);

    // Oversize header and out-of-range write both reject the message
    do_reset();
    do_hdr(8'h41, 16'd1);
    do_write(16'd0, 8'h41);
    do_end(1'b1, 1'b0, 1'b0);
    do_hdr(8'h42, 16'd1025);
    do_write(16'd0, 8'h55);
    do_end(1'b1, 1'b0, 1'b0);
    checkOutput("t4_bad1",  32'(bad_cnt),    1);
    checkOutput("t4_flag",  32'(msg_flag_o), 'h41);
    do_hdr(8'h43, 16'd2);
    do_write(16'h0400, 8'h66);
    do_write(16'd1, 8'h67);
    do_end(1'b1, 1'b0, 1'b0);
    checkOutput("t4_bad2",  32'(bad_cnt), 2);
    do_read('0);
    checkOutput("t4_rd_intact", 32'(rd_data), 'h41);

    // wr_req held high: one pulse, one write
    do_reset();
    do_hdr(8'h51, 16'd2);
    wr_addr = 16'd0;
    wr_data = 8'h5A;
    wr_req  = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_rdy) pulses++;
      else if (pulses == 1) wr_data = 8'hEE;
    end
    checkOutput("t5_pulses", 32'(pulses), 1);
    wr_req = 1'b0;
    repeat (2) tick();
    do_write(16'd1, 8'h5B);
    do_end(1'b1, 1'b0, 1'b0);
    do_read('0);
    checkOutput("t5_rd0", 32'(rd_data), 'h5A);
    do_read(ADDR_W'(1));
    checkOutput("t5_rd1", 32'(rd_data), 'h5B);

    // Asynchronous reset mid-message with a READY bank and a pending write
    do_reset();
    do_hdr(8'h60, 16'd1);
    do_end(1'b0, 1'b0, 1'b0);
    do_hdr(8'h61, 16'd2);
    do_write(16'd0, 8'h61);
    do_end(1'b1, 1'b0, 1'b0);
    do_hdr(8'h62, 16'd2);
    wr_addr = 16'd1;
    wr_data = 8'h99;
    wr_req  = 1'b1;
    tick();
    #2 rst_h = 1'b1;
    #1;
    checkOutput("t6_avail", 32'(msg_avail), 0);
    checkOutput("t6_bad",   32'(bad_cnt),   0);
    checkOutput("t6_rdy",   32'(wr_rdy),    0);
    tick();
    rst_h = 1'b0;
    wait_rdy();
    checkOutput("t6_avail_after", 32'(msg_avail), 0);
    do_hdr(8'h63, 16'd1);
    do_write(16'd0, 8'h63);
    do_end(1'b1, 1'b1, 1'b0);
    checkOutput("t6_flag", 32'(msg_flag_o), 'h63);
    do_read('0);
    checkOutput("t6_rd", 32'(rd_data), 'h63);

    // Counter saturation
    do_reset();
    repeat (260) begin
      do_hdr(8'h70, 16'd1);
      do_end(1'b0, 1'b0, 1'b0);
    end
    checkOutput("sat_bad", 32'(bad_cnt), 255);
    repeat (2) begin
      do_hdr(8'h71, 16'd1);
      do_end(1'b1, 1'b0, 1'b0);
    end
    repeat (260) begin
      do_hdr(8'h72, 16'd1);
      do_end(1'b1, 1'b0, 1'b0);
    end
    checkOutput("sat_drop", 32'(drop_cnt), 255);

    // Randomized traffic against the model
    do_reset();
    applyStimulus(400);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
